// File: rtl/mont_pkg.sv
// Shared constants and FSM encoding for the Montgomery multiply/reduce block.
package mont_pkg;

    localparam int WIDTH_DEF = 17;
    localparam int RBITS_DEF = 17;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_MUL  = 3'd1,
        S_MRED = 3'd2,
        S_ADD  = 3'd3,
        S_FIN  = 3'd4
    } state_t;

endpackage

// File: rtl/mont_redc_mul_if.sv
// Request/response bundle of mont_redc_mul: operands and modulus in, busy/done/result out.
interface mont_redc_mul_if import mont_pkg::*; #(
    parameter int WIDTH = WIDTH_DEF,
    parameter int RBITS = RBITS_DEF
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] q;
    logic [RBITS-1:0] n_prime;
    logic             busy;
    logic             done;
    logic [WIDTH:0]   c;

    modport master (
        output start, a, b, q, n_prime,
        input  busy, done, c
    );

    modport slave (
        input  start, a, b, q, n_prime,
        output busy, done, c
    );
endinterface

// File: rtl/mont_csub.sv
// Final conditional subtraction: brings a lazily reduced value in [0,2q) into [0,q).
module mont_csub #(
    parameter int WIDTH = 17
) (
    input  logic [WIDTH:0]   i_t,
    input  logic [WIDTH-1:0] i_q,
    output logic [WIDTH:0]   o_c
);
    logic [WIDTH:0] w_qx;

    assign w_qx = {1'b0, i_q};
    assign o_c  = (i_t >= w_qx) ? (i_t - w_qx) : i_t;
endmodule

// File: rtl/mont_redc_mul.sv
// Montgomery product c = a*b*R^-1 mod q, one FSM state per cycle, fixed 5-cycle latency.
// Define MONT_FINAL_SUB_EN to fully reduce c into [0,q); otherwise c is lazily reduced in [0,2q).
module mont_redc_mul import mont_pkg::*; #(
    parameter int WIDTH = WIDTH_DEF,
    parameter int RBITS = RBITS_DEF
) (
    input  logic           clk,
    input  logic           reset,
    mont_redc_mul_if.slave bus
);
    localparam int PW = 2 * WIDTH;
    localparam int SW = 2 * WIDTH + 2;

    state_t r_state;
    state_t w_next;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_q;
    logic [RBITS-1:0] r_np;
    logic [PW-1:0]    r_prod_p1;
    logic [RBITS-1:0] r_m_p2;
    logic [WIDTH:0]   r_t_p3;
    logic [WIDTH:0]   r_c;
    logic             r_done;

    logic [PW-1:0]    w_prod;
    logic [RBITS-1:0] w_m;
    logic [SW-1:0]    w_sum;
    logic [WIDTH:0]   w_t;
    logic [WIDTH:0]   w_c;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (bus.start) w_next = S_MUL;
            S_MUL:   w_next = S_MRED;
            S_MRED:  w_next = S_ADD;
            S_ADD:   w_next = S_FIN;
            S_FIN:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // T + m*q is exactly divisible by R; the sum keeps two guard bits so nothing is lost.
    assign w_prod = PW'(r_a) * PW'(r_b);
    assign w_m    = RBITS'(r_prod_p1) * r_np;
    assign w_sum  = SW'(r_prod_p1) + SW'(r_m_p2) * SW'(r_q);
    assign w_t    = (WIDTH+1)'(w_sum >> RBITS);

`ifdef MONT_FINAL_SUB_EN
    mont_csub #(
        .WIDTH (WIDTH)
    ) u_csub (
        .i_t (r_t_p3),
        .i_q (r_q),
        .o_c (w_c)
    );
`else
    assign w_c = r_t_p3;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_a       <= '0;
            r_b       <= '0;
            r_q       <= '0;
            r_np      <= '0;
            r_prod_p1 <= '0;
            r_m_p2    <= '0;
            r_t_p3    <= '0;
            r_c       <= '0;
            r_done    <= 1'b0;
        end else begin
            r_done <= (r_state == S_FIN);
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_a  <= bus.a;
                        r_b  <= bus.b;
                        r_q  <= bus.q;
                        r_np <= bus.n_prime;
                    end
                end
                S_MUL:   r_prod_p1 <= w_prod;
                S_MRED:  r_m_p2    <= w_m;
                S_ADD:   r_t_p3    <= w_t;
                S_FIN:   r_c       <= w_c;
                default: ;
            endcase
        end
    end

    assign bus.busy = (r_state != S_IDLE);
    assign bus.done = r_done;
    assign bus.c    = r_c;
endmodule

// File: tb/tb_mont_redc_mul.sv
// Randomized bench for mont_redc_mul with a plain-arithmetic Montgomery model and per-cycle compare.
module tb_mont_redc_mul;
    import mont_pkg::*;

    localparam int     W  = 17;
    localparam int     RB = 17;
    localparam longint R  = longint'(1) << RB;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    mont_redc_mul_if #(.WIDTH(W), .RBITS(RB)) bus ();

    mont_redc_mul #(.WIDTH(W), .RBITS(RB)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        longint a;
        longint b;
        longint q;
        longint expc;
        int     acc;
    } exp_t;

    exp_t   expq[$];
    int     total = 0;
    int     bad = 0;
    int     cyc = 0;
    int     last_acc = -100;
    int     done_cnt = 0;
    longint last_c = 0;
    logic [W-1:0]  cur_q;
    logic [RB-1:0] cur_np;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string nm, longint act, longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic longint model_c(longint a, longint b, longint q, longint np);
        longint tf, m, t;
        tf = a * b;
        m  = ((tf % R) * np) % R;
        t  = (tf + m * q) / R;
`ifdef MONT_FINAL_SUB_EN
        if (t >= q) t = t - q;
`endif
        return t;
    endfunction

    // -q^-1 mod R by Newton iteration; an odd q is its own inverse mod 8.
    function automatic longint calc_np(longint q);
        longint inv;
        inv = q;
        for (int i = 0; i < 5; i++)
            inv = (inv * ((2 - q * inv) & (R - 1))) & (R - 1);
        return (R - inv) & (R - 1);
    endfunction

    task automatic step(bit st, longint av, longint bv);
        exp_t e;
        @(negedge clk);
        bus.start   = st;
        bus.a       = W'(av);
        bus.b       = W'(bv);
        bus.q       = cur_q;
        bus.n_prime = cur_np;
        if (st && !reset && cyc >= last_acc + 4) begin
            e.a    = av;
            e.b    = bv;
            e.q    = cur_q;
            e.expc = model_c(av, bv, cur_q, cur_np);
            e.acc  = cyc + 1;
            expq.push_back(e);
            last_acc = cyc + 1;
        end
    endtask

    always @(negedge clk) begin
        bit   exp_busy, exp_done;
        exp_t e;
        if (!reset) begin
            exp_busy = (cyc >= last_acc) && (cyc <= last_acc + 3);
            exp_done = (expq.size() > 0) && (cyc == expq[0].acc + 4);
            chk("busy", bus.busy, exp_busy);
            chk("done", bus.done, exp_done);
            if (bus.done) done_cnt++;
            if (exp_done) begin
                e = expq.pop_front();
                chk("c_model", bus.c, e.expc);
                if (e.a < e.q && e.b < e.q) begin
                    chk("c_mod", (longint'(bus.c) * R) % e.q, (e.a * e.b) % e.q);
                    if (e.q == 17) chk("c_mod17", longint'(bus.c) % 17, (e.a * e.b * 9) % 17);
`ifdef MONT_FINAL_SUB_EN
                    chk("c_lt_q", longint'(bus.c < e.q), 1);
`else
                    chk("c_lt_2q", longint'(bus.c < 2 * e.q), 1);
`endif
                end
            end
            if (bus.done) last_c = bus.c;
            else          chk("c_hold", bus.c, last_c);
        end
    end

    task automatic do_reset();
        #2 reset = 1'b1;
        expq.delete();
        last_acc  = -100;
        last_c    = 0;
        bus.start = 1'b0;
        #1;
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_c", bus.c, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2 reset = 1'b0;
    endtask

    task automatic run_lit(string nm, longint av, longint bv, longint expc);
        int n;
        bit got;
        n   = 0;
        got = 1'b0;
        step(1'b1, av, bv);
        while (!got && n < 12) begin
            step(1'b0, $urandom_range(0, 16), $urandom_range(0, 16));
            n++;
            if (bus.done) begin
                got = 1'b1;
                chk({nm, "_c"}, bus.c, expc);
                chk({nm, "_lat"}, n, 5);
            end
        end
        chk({nm, "_done_seen"}, got, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d1, d2, dc0;
        longint c1, c2, qq, np, av, bv;
        bus.start   = 1'b0;
        bus.a       = '0;
        bus.b       = '0;
        cur_q       = W'(17);
        cur_np      = RB'(69391);
        bus.q       = cur_q;
        bus.n_prime = cur_np;

        repeat (2) @(negedge clk);
        chk("init_busy", bus.busy, 0);
        chk("init_done", bus.done, 0);
        chk("init_c", bus.c, 0);
        #2 reset = 1'b0;

        // Hand-derived values for q=17, R=2^17 pin the model itself.
        chk("np_17", calc_np(17), 69391);
        chk("model_1x1", model_c(1, 1, 17, 69391), 9);
        chk("model_2x16", model_c(2, 16, 17, 69391), 16);
        chk("model_16x16", model_c(16, 16, 17, 69391), 9);

        run_lit("lit_1x1", 1, 1, 9);
        run_lit("lit_2x16", 2, 16, 16);
        run_lit("lit_0x5", 0, 5, 0);

        // start held through busy and into the done cycle: second op accepted there.
        d1 = -1; d2 = -1; c1 = -1; c2 = -1;
        step(1'b1, 1, 1);
        for (int i = 1; i <= 14; i++) begin
            step(i <= 5, 2, 16);
            if (bus.done) begin
                if (d1 < 0) begin d1 = cyc; c1 = bus.c; end
                else        begin d2 = cyc; c2 = bus.c; end
            end
        end
        chk("b2b_c1", c1, 9);
        chk("b2b_c2", c2, 16);
        chk("b2b_gap", d2 - d1, 5);

        // start pulses with new operands while busy must be ignored.
        dc0 = done_cnt;
        c1  = -1;
        step(1'b1, 3, 5);
        repeat (4) step(1'b1, $urandom_range(0, 16), $urandom_range(0, 16));
        for (int i = 0; i < 10; i++) begin
            step(1'b0, $urandom_range(0, 16), $urandom_range(0, 16));
            if (bus.done) c1 = bus.c;
        end
        chk("busy_ign_cnt", done_cnt - dc0, 1);
        chk("busy_ign_c", c1, 16);

        // Reset while the operation sits in ADD.
        step(1'b1, 5, 7);
        repeat (3) step(1'b0, 0, 0);
        dc0 = done_cnt;
        do_reset();
        repeat (6) step(1'b0, 0, 0);
        chk("rst_no_done", done_cnt - dc0, 0);
        run_lit("post_rst_16x16", 16, 16, 9);

        for (int a = 0; a < 17; a++) begin
            for (int b = 0; b < 17; b++) begin
                step(1'b1, a, b);
                repeat (4) step(1'b0, $urandom_range(0, 16), $urandom_range(0, 16));
            end
        end
        repeat (6) step(1'b0, 0, 0);

        for (int k = 0; k < 60; k++) begin
            qq = longint'($urandom_range(1, 65535)) * 2 + 1;
            np = calc_np(qq);
            cur_q  = W'(qq);
            cur_np = RB'(np);
            chk("np_inv", (qq * ((R - np) & (R - 1))) & (R - 1), 1);
            av = longint'($urandom_range(0, 131071)) % qq;
            bv = longint'($urandom_range(0, 131071)) % qq;
            step(1'b1, av, bv);
            repeat (4 + $urandom_range(0, 2))
                step($urandom_range(0, 1) == 1, $urandom_range(0, 131071), $urandom_range(0, 131071));
            step(1'b0, 0, 0);
        end
        repeat (8) step(1'b0, 0, 0);
        chk("drain", expq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
